// File: rtl/ray_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : ray_result_collector
// Purpose  : Collects one-cycle ray results from raytracer_top, tags each with
//            a sequential pixel index, buffers them in a show-ahead FIFO and
//            streams them to the framebuffer writer over valid/ready. Keeps
//            per-frame hit/miss/timeout statistics and issues a credit
//            (o_job_allow) so no launched ray can find the buffer full.
// Ports    : clk, rst_n (async, active-low)
//            i_job_fire / o_job_allow      : dispatcher handshake and credit
//            i_frame_clear                 : synchronous frame restart
//            i_ray_done, i_ray_hit, i_ray_timeout, i_hit_voxel_x/y/z,
//            i_hit_face_id, i_steps_taken  : result from raytracer_top
//            o_res_valid / i_res_ready     : result stream handshake
//            o_res_pixel_idx, o_res_hit, o_res_timeout, o_res_x/y/z,
//            o_res_face, o_res_steps       : head entry of the FIFO
//            o_frame_done                  : pulse after last pixel pushed
//            o_stat_hits/misses/timeouts   : saturating per-frame counters
//            o_overflow                    : sticky, a result was dropped
// Revision : 1.0 - initial release
// ============================================================================
module ray_result_collector #(
    parameter int COORD_WIDTH      = 16,
    parameter int STEP_COUNT_WIDTH = 16,
    parameter int DEPTH            = 8,
    parameter int PIX_BITS         = 16,
    parameter int FRAME_PIXELS     = 1024,
    parameter int STAT_W           = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_job_fire,
    output logic                        o_job_allow,
    input  logic                        i_frame_clear,
    input  logic                        i_ray_done,
    input  logic                        i_ray_hit,
    input  logic                        i_ray_timeout,
    input  logic [COORD_WIDTH-1:0]      i_hit_voxel_x,
    input  logic [COORD_WIDTH-1:0]      i_hit_voxel_y,
    input  logic [COORD_WIDTH-1:0]      i_hit_voxel_z,
    input  logic [2:0]                  i_hit_face_id,
    input  logic [STEP_COUNT_WIDTH-1:0] i_steps_taken,
    output logic                        o_res_valid,
    input  logic                        i_res_ready,
    output logic [PIX_BITS-1:0]         o_res_pixel_idx,
    output logic                        o_res_hit,
    output logic                        o_res_timeout,
    output logic [COORD_WIDTH-1:0]      o_res_x,
    output logic [COORD_WIDTH-1:0]      o_res_y,
    output logic [COORD_WIDTH-1:0]      o_res_z,
    output logic [2:0]                  o_res_face,
    output logic [STEP_COUNT_WIDTH-1:0] o_res_steps,
    output logic                        o_frame_done,
    output logic [STAT_W-1:0]           o_stat_hits,
    output logic [STAT_W-1:0]           o_stat_misses,
    output logic [STAT_W-1:0]           o_stat_timeouts,
    output logic                        o_overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = PIX_BITS + 2 + 3 * COORD_WIDTH + 3 + STEP_COUNT_WIDTH;

    localparam logic [PIX_BITS-1:0] c_LAST_PIX = PIX_BITS'(FRAME_PIXELS - 1);
    localparam logic [c_CNT_W-1:0]  c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [STAT_W-1:0]   c_STAT_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  r_inflight;
    logic [PIX_BITS-1:0] r_pix;
    logic [STAT_W-1:0]   r_hits;
    logic [STAT_W-1:0]   r_misses;
    logic [STAT_W-1:0]   r_timeouts;
    logic                r_overflow;
    logic                r_frame_done;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_is_hit;
    logic               w_is_timeout;
    logic               w_is_miss;
    logic [c_CNT_W:0]   w_credit_sum;
    logic [c_CNT_W-1:0] w_inflight_nxt;
    logic [c_ENT_W-1:0] w_entry;
    logic [c_ENT_W-1:0] w_head;

    assign w_full = (r_count == c_DEPTH);
    // frame_clear overrides every other action in the cycle it is asserted.
    assign w_pop  = ~i_frame_clear & (r_count != '0) & i_res_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = ~i_frame_clear & i_ray_done & (~w_full | w_pop);
    assign w_drop = ~i_frame_clear & i_ray_done & w_full & ~w_pop;

    // Hit outranks timeout; anything else is a miss.
    assign w_is_hit     = i_ray_hit;
    assign w_is_timeout = ~i_ray_hit & i_ray_timeout;
    assign w_is_miss    = ~i_ray_hit & ~i_ray_timeout;

    // Credit uses registered state only, so no combinational path from
    // the consumer's ready reaches the dispatcher.
    assign w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};
    assign o_job_allow  = (w_credit_sum < {1'b0, c_DEPTH});

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (i_job_fire && !i_ray_done) begin
            if (r_inflight != '1) begin
                w_inflight_nxt = r_inflight + 1'b1;
            end
        end else if (!i_job_fire && i_ray_done) begin
            // An unsolicited result must not underflow the counter.
            if (r_inflight != '0) begin
                w_inflight_nxt = r_inflight - 1'b1;
            end
        end
    end

    assign w_entry = {r_pix, w_is_hit, w_is_timeout, i_hit_voxel_x, i_hit_voxel_y,
                      i_hit_voxel_z, i_hit_face_id, i_steps_taken};

    // ------------------------------------------------------------------
    // Storage: cleared on reset so the head fields read zero while empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else if (i_frame_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel tagging, frame pulse, statistics and overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix        <= '0;
            r_frame_done <= 1'b0;
            r_hits       <= '0;
            r_misses     <= '0;
            r_timeouts   <= '0;
            r_overflow   <= 1'b0;
        end else if (i_frame_clear) begin
            r_pix        <= '0;
            r_frame_done <= 1'b0;
            r_hits       <= '0;
            r_misses     <= '0;
            r_timeouts   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_push && (r_pix == c_LAST_PIX);
            if (w_push) begin
                r_pix <= (r_pix == c_LAST_PIX) ? '0 : r_pix + 1'b1;
                if (w_is_hit && (r_hits != c_STAT_MAX)) begin
                    r_hits <= r_hits + 1'b1;
                end
                if (w_is_timeout && (r_timeouts != c_STAT_MAX)) begin
                    r_timeouts <= r_timeouts + 1'b1;
                end
                if (w_is_miss && (r_misses != c_STAT_MAX)) begin
                    r_misses <= r_misses + 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head entry presented straight from storage (show-ahead).
    // ------------------------------------------------------------------
    assign w_head      = r_mem[r_rd_ptr];
    assign o_res_valid = (r_count != '0);
    assign {o_res_pixel_idx, o_res_hit, o_res_timeout, o_res_x, o_res_y,
            o_res_z, o_res_face, o_res_steps} = w_head;

    assign o_frame_done    = r_frame_done;
    assign o_stat_hits     = r_hits;
    assign o_stat_misses   = r_misses;
    assign o_stat_timeouts = r_timeouts;
    assign o_overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ray_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_result_collector
// Purpose  : Directed, scoreboard-checked bench for ray_result_collector.
//            Stimulus pushes expected entries into a queue; a monitor pops
//            and compares every accepted output beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_result_collector;

    localparam int CW  = 16;
    localparam int SW  = 16;
    localparam int DP  = 8;
    localparam int PB  = 16;
    localparam int FP  = 4;
    localparam int STW = 4;
    localparam int EW  = PB + 2 + 3 * CW + 3 + SW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           job_fire, job_allow, frame_clear;
    logic           ray_done, ray_hit, ray_timeout;
    logic [CW-1:0]  hx, hy, hz;
    logic [2:0]     face;
    logic [SW-1:0]  steps;
    logic           res_valid, res_ready;
    logic [PB-1:0]  res_pix;
    logic           res_hit, res_to;
    logic [CW-1:0]  res_x, res_y, res_z;
    logic [2:0]     res_face;
    logic [SW-1:0]  res_steps;
    logic           frame_done, overflow;
    logic [STW-1:0] st_hits, st_misses, st_to;

    int n_total = 0;
    int n_pass  = 0;

    logic [EW-1:0] exp_q[$];
    logic [PB-1:0] exp_pix = '0;

    always #5 clk = ~clk;

    ray_result_collector #(
        .COORD_WIDTH(CW), .STEP_COUNT_WIDTH(SW), .DEPTH(DP),
        .PIX_BITS(PB), .FRAME_PIXELS(FP), .STAT_W(STW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_job_fire(job_fire), .o_job_allow(job_allow),
        .i_frame_clear(frame_clear),
        .i_ray_done(ray_done), .i_ray_hit(ray_hit), .i_ray_timeout(ray_timeout),
        .i_hit_voxel_x(hx), .i_hit_voxel_y(hy), .i_hit_voxel_z(hz),
        .i_hit_face_id(face), .i_steps_taken(steps),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_pixel_idx(res_pix), .o_res_hit(res_hit), .o_res_timeout(res_to),
        .o_res_x(res_x), .o_res_y(res_y), .o_res_z(res_z),
        .o_res_face(res_face), .o_res_steps(res_steps),
        .o_frame_done(frame_done),
        .o_stat_hits(st_hits), .o_stat_misses(st_misses), .o_stat_timeouts(st_to),
        .o_overflow(overflow)
    );

    // Monitor: every beat accepted by the consumer is compared in order.
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        if (rst_n && res_valid && res_ready) begin
            act = {res_pix, res_hit, res_to, res_x, res_y, res_z, res_face, res_steps};
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected: got %h, required no beat", act);
            end else begin
                e = exp_q.pop_front();
                if (act === e) n_pass++;
                else $display("FAIL pop_entry: got %h, required %h", act, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    task automatic done(input logic h, input logic t, input logic [CW-1:0] x,
                        input logic [CW-1:0] y, input logic [CW-1:0] z,
                        input logic [2:0] f, input logic [SW-1:0] s, input bit acc);
        ray_done = 1'b1; ray_hit = h; ray_timeout = t;
        hx = x; hy = y; hz = z; face = f; steps = s;
        if (acc) begin
            exp_q.push_back({exp_pix, h, t & ~h, x, y, z, f, s});
            exp_pix = (exp_pix == PB'(FP - 1)) ? '0 : exp_pix + 1'b1;
        end
        step();
        ray_done = 1'b0;
    endtask

    task automatic fire();
        job_fire = 1'b1;
        step();
        job_fire = 1'b0;
    endtask

    task automatic clear();
        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        exp_q.delete();
        exp_pix = '0;
    endtask

    initial begin
        rst_n = 1'b0; job_fire = 0; frame_clear = 0; ray_done = 0;
        ray_hit = 0; ray_timeout = 0; hx = 0; hy = 0; hz = 0; face = 0;
        steps = 0; res_ready = 0;
        #12;
        // Reset state
        chk("rst_valid", 64'(res_valid), 0);
        chk("rst_allow", 64'(job_allow), 1);
        chk("rst_flags", 64'({overflow, frame_done}), 0);
        chk("rst_stats", 64'({st_hits, st_misses, st_to}), 0);
        chk("rst_data", 64'({res_pix, res_x}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Single hit with one-cycle latency
        res_ready = 1'b1;
        fire();
        chk("t1_allow_fire", 64'(job_allow), 1);
        done(1, 0, 5, 0, 0, 1, 5, 1);
        chk("t1_latency", 64'(res_valid), 1);
        chk("t1_hits", 64'(st_hits), 1);
        chk("t1_allow", 64'(job_allow), 1);
        step();
        chk("t1_empty", 64'(res_valid), 0);

        // Credit / back-pressure
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fire();
            chk("t2_allow_fire", 64'(job_allow), (i == 7) ? 64'd0 : 64'd1);
            done(0, 0, CW'(i), CW'(i + 1), CW'(i + 2), 3'd2, SW'(i + 3), 1);
        end
        chk("t2_allow_full", 64'(job_allow), 0);
        chk("t2_valid_full", 64'(res_valid), 1);
        res_ready = 1'b1;
        step();
        chk("t2_allow_back", 64'(job_allow), 1);
        repeat (7) step();
        chk("t2_drained", 64'(res_valid), 0);

        // Overflow
        clear();
        res_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            done(0, 1, CW'(10 + i), 0, 0, 3'd4, SW'(i), (i < 8));
        end
        chk("t3_overflow", 64'(overflow), 1);
        chk("t3_stats", 64'({st_hits, st_misses, st_to}), 64'(12'h008));
        chk("t3_allow", 64'(job_allow), 0);
        res_ready = 1'b1;
        done(1, 0, 99, 1, 2, 3'd5, 7, 1);   // push and pop while full
        chk("t3_full_pp_valid", 64'(res_valid), 1);
        chk("t3_full_pp_allow", 64'(job_allow), 0);
        chk("t3_full_pp_hits", 64'(st_hits), 1);
        repeat (8) step();
        chk("t3_drained", 64'(res_valid), 0);
        chk("t3_sticky", 64'(overflow), 1);

        // Classification
        clear();
        chk("t4_ovf_clr", 64'(overflow), 0);
        chk("t4_stats_clr", 64'({st_hits, st_misses, st_to}), 0);
        done(1, 1, 1, 1, 1, 3'd0, 1, 1);
        done(0, 1, 2, 2, 2, 3'd1, 2, 1);
        done(0, 0, 3, 3, 3, 3'd2, 3, 1);
        step();
        chk("t4_stats", 64'({st_hits, st_misses, st_to}), 64'(12'h111));
        chk("t4_no_fdone", 64'(frame_done), 0);

        // Frame wrap
        done(1, 0, 4, 4, 4, 3'd3, 4, 1);    // index 3
        chk("t5_fdone", 64'(frame_done), 1);
        done(0, 0, 5, 5, 5, 3'd4, 5, 1);    // index 0
        chk("t5_fdone_once", 64'(frame_done), 0);
        step();
        chk("t5_fdone_low", 64'(frame_done), 0);

        // frame_clear with queued entries and in-flight jobs
        clear();
        res_ready = 1'b0;
        done(1, 0, 1, 0, 0, 3'd1, 1, 1);
        done(0, 1, 2, 0, 0, 3'd1, 2, 1);
        done(0, 0, 3, 0, 0, 3'd1, 3, 1);
        repeat (5) fire();
        chk("t6_allow_low", 64'(job_allow), 0);
        frame_clear = 1'b1; ray_done = 1'b1; ray_hit = 1'b1; job_fire = 1'b1;
        step();
        frame_clear = 1'b0; ray_done = 1'b0; job_fire = 1'b0; ray_hit = 1'b0;
        exp_q.delete();
        exp_pix = '0;
        chk("t6_valid", 64'(res_valid), 0);
        chk("t6_stats", 64'({st_hits, st_misses, st_to}), 0);
        chk("t6_allow", 64'(job_allow), 1);
        chk("t6_fdone", 64'(frame_done), 0);
        res_ready = 1'b1;
        done(0, 0, 7, 8, 9, 3'd3, 10, 1);
        step();
        chk("t6_post_miss", 64'(st_misses), 1);
        chk("t6_post_empty", 64'(res_valid), 0);

        // Statistic saturation
        clear();
        for (int i = 0; i < 17; i++) begin
            done(1, 0, CW'(i), 0, 0, 3'd0, 0, 1);
        end
        step();
        chk("t7_sat", 64'(st_hits), 64'd15);

        // Asynchronous reset mid-stream
        res_ready = 1'b0;
        done(1, 0, 33, 1, 1, 3'd2, 9, 1);
        done(1, 0, 34, 1, 1, 3'd2, 9, 1);
        chk("t8_valid_pre", 64'(res_valid), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t8_valid", 64'(res_valid), 0);
        chk("t8_data", 64'({res_pix, res_x, res_steps}), 0);
        chk("t8_stats", 64'({st_hits, st_misses, st_to}), 0);
        chk("t8_allow", 64'(job_allow), 1);
        exp_q.delete();
        exp_pix = '0;
        step();
        rst_n = 1'b1;
        step();

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ray_result_collector.md
Name: ray_result_collector

Overview:
- Sits directly downstream of raytracer_top and consumes its one-cycle ray_done result pulse plus the hit, timeout, voxel, face and step fields.
- Tags each result with a sequential pixel index and buffers it in a show-ahead FIFO.
- Presents results on a valid/ready stream to the framebuffer writer and keeps per-frame hit/miss/timeout statistics.
- Issues a credit signal, job_allow, so the job dispatcher never launches a ray whose result could not be buffered.

Parameters:
COORD_WIDTH, 16, width of hit voxel coordinates
STEP_COUNT_WIDTH, 16, width of steps_taken
DEPTH, 8, FIFO entries (power of two, >=2)
PIX_BITS, 16, width of pixel index
FRAME_PIXELS, 1024, pixels per frame (<= 2^PIX_BITS)
STAT_W, 32, width of statistic counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
job_fire  in  1  dispatcher handshake (job_valid & job_ready) into raytracer_top
job_allow  out  1  dispatcher may fire a job this cycle
frame_clear  in  1  synchronous frame restart
ray_done  in  1  result pulse from raytracer_top
ray_hit  in  1  ray hit a voxel
ray_timeout  in  1  ray exhausted max_steps
hit_voxel_x/y/z  in  COORD_WIDTH each  hit voxel coordinates
hit_face_id  in  3  face entered
steps_taken  in  STEP_COUNT_WIDTH  DDA steps used
res_valid  out  1  result available
res_ready  in  1  consumer accepts
res_pixel_idx  out  PIX_BITS  pixel tag
res_hit, res_timeout  out  1 each  classification
res_x/res_y/res_z  out  COORD_WIDTH each  voxel coordinates
res_face  out  3  face id
res_steps  out  STEP_COUNT_WIDTH  steps
frame_done  out  1  one-cycle pulse when the last pixel of the frame is written
stat_hits, stat_misses, stat_timeouts  out  STAT_W each  per-frame counts
overflow  out  1  sticky: a result was dropped

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; pointers, count and inflight are 0.
  - Pixel counter, stats, overflow, frame_done and res_valid are 0.
  - res_* data fields read 0.
- Inflight counter:
  - job_fire increments it; ray_done decrements it; both in the same cycle leave it unchanged.
  - ray_done with inflight=0 is still accepted and the counter holds at 0.
- Credit: job_allow = (count + inflight) < DEPTH. It is combinational from registers only, with no path from res_ready.
- Push:
  - On ray_done, write {pixel_idx, hit, timeout, x, y, z, face, steps} at the write pointer.
  - pixel_idx increments after each push and wraps to 0 after FRAME_PIXELS-1.
  - frame_done pulses on the cycle after pushing index FRAME_PIXELS-1.
- Classification:
  - hit has priority: ray_hit=1 gives res_hit=1 and res_timeout=0.
  - Otherwise, ray_timeout=1 counts as a timeout.
  - Otherwise the result is a miss.
  - Exactly one stat counter increments per accepted push. Counters saturate at 2^STAT_W-1.
- Pop:
  - res_valid = count != 0. res_* show the head entry combinationally from the storage array.
  - Pop occurs when res_valid & res_ready.
  - Latency: ray_done in cycle N gives res_valid high in cycle N+1 when the FIFO was empty.
- Full:
  - If count==DEPTH and there is no pop in the same cycle, ray_done is dropped. overflow is set; pixel_idx and stats do not change.
  - Push and pop together while full: both take effect and count stays at DEPTH.
  - Push and pop together while empty: the push is taken, no pop occurs, and count becomes 1.
- Stream rule: the head entry and res_valid stay stable while res_valid=1 and res_ready=0.
- frame_clear (synchronous, highest priority):
  - Flushes the FIFO (count=0).
  - Zeroes inflight, pixel_idx, stats and overflow.
  - Discards any ray_done and job_fire in the same cycle.
  - frame_done is 0 on the following cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation clears all state immediately; no partial entry survives.

Test Plan:
- Single hit: job_fire, then ray_done with hit=1, (5,0,0), face 1, steps 5, res_ready=1 -> res_valid the next cycle with pixel_idx=0, res_x=5, stat_hits=1, job_allow=1 throughout.
- Credit/back-pressure (DEPTH=8): res_ready=0; fire and complete 8 rays with 1 in flight maximum -> job_allow drops to 0 when count+inflight=8. Results pop in order with idx 0..7, and job_allow returns after the first pop.
- Overflow: force 9 ray_done pulses with res_ready=0 -> 9th dropped, overflow=1, count=8, stats total 8, next pixel_idx=8.
- Classification: results (hit=1, timeout=1), (0,1), (0,0) -> res_hit/res_timeout = 1/0, 0/1, 0/0; stat_hits=1, stat_timeouts=1, stat_misses=1.
- Frame wrap (FRAME_PIXELS=4): 5 results -> frame_done pulses once, after idx 3; 5th result carries idx 0.
- frame_clear with 3 queued entries and a coincident ray_done -> res_valid=0 next cycle, stats 0, next push gets idx 0; async rst_n low mid-stream -> all outputs 0 immediately.
